// File: rtl/rr_arb_reg_slice_if.sv
// Handshake bundle for rr_arb_reg_slice.
//   iVld/iLast/iDat : per-requester beat valid, last flag and payload
//   iRdy            : per-requester accept (one-hot or zero)
//   oVld/oDat/oLast : registered output beat
//   oSrc            : index of the requester that produced the output beat
//   oRdy            : downstream accept
// The slice uses the slave modport; the requester/consumer side uses master.
interface rr_arb_reg_slice_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            iVld;
    logic [NUM_REQ-1:0]            iLast;
    logic [NUM_REQ*DATA_WIDTH-1:0] iDat;
    logic [NUM_REQ-1:0]            iRdy;
    logic                          oVld;
    logic [DATA_WIDTH-1:0]         oDat;
    logic                          oLast;
    logic [SRC_W-1:0]              oSrc;
    logic                          oRdy;

    modport slave (
        input  iVld, iLast, iDat, oRdy,
        output iRdy, oVld, oDat, oLast, oSrc
    );

    modport master (
        output iVld, iLast, iDat, oRdy,
        input  iRdy, oVld, oDat, oLast, oSrc
    );
endinterface

// File: rtl/rr_arb_reg_slice.sv
// Round-robin, packet-aware arbiter feeding a single output register slice.
// Whole packets are kept together: once a multi-beat packet starts, its
// owner is locked in until the beat flagged last has been accepted.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous, active-high reset
//   bus : rr_arb_reg_slice_if.slave (requester inputs, registered output)
module rr_arb_reg_slice #(
    parameter int                    NUM_REQ    = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INI_DATA   = '0
) (
    input  logic               clk,
    input  logic               rst,
    rr_arb_reg_slice_if.slave  bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = SRC_W + 1;

    typedef enum logic {ARB, LOCK} state_t;

    state_t                state_q;
    logic [SRC_W-1:0]      owner_q;
    logic [SRC_W-1:0]      ptr_q;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  last_q;
    logic [SRC_W-1:0]      src_q;

    logic                  ld_en;
    logic [DATA_WIDTH-1:0] dat_arr [NUM_REQ];
    logic [2*NUM_REQ-1:0]  vld_dbl;
    logic [NUM_REQ-1:0]    vld_rot;
    logic                  arb_found;
    logic [SRC_W-1:0]      offset;
    logic [SUM_W-1:0]      grant_sum;
    logic                  grant_ok;
    logic [SRC_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    rdy;
    logic                  xfer;
    logic                  xfer_last;
    logic [SRC_W-1:0]      ptr_inc;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign dat_arr[k] = bus.iDat[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // The register can take a new beat when it is empty or being drained.
    assign ld_en = !vld_q || bus.oRdy;

    // Rotate the valid vector so that bit 0 is the requester at ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign vld_dbl = {bus.iVld, bus.iVld};
    assign vld_rot = vld_dbl[{1'b0, ptr_q} +: NUM_REQ];

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        arb_found = 1'b0;
        offset    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vld_rot[i]) begin
                arb_found = 1'b1;
                offset    = SRC_W'(i);
            end
        end

        // Undo the rotation: (ptr + offset) mod NUM_REQ.
        grant_sum = {1'b0, ptr_q} + {1'b0, offset};
        if (grant_sum >= SUM_W'(NUM_REQ)) begin
            grant_sum = grant_sum - SUM_W'(NUM_REQ);
        end

        if (state_q == LOCK) begin
            grant_ok  = 1'b1;
            grant_idx = owner_q;
        end else begin
            grant_ok  = arb_found;
            grant_idx = grant_sum[SRC_W-1:0];
        end

        rdy = '0;
        if (!rst && ld_en && grant_ok) begin
            rdy[grant_idx] = 1'b1;
        end

        xfer      = |(rdy & bus.iVld);
        xfer_last = bus.iLast[grant_idx];
        ptr_inc   = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            owner_q <= '0;
            ptr_q   <= '0;
            vld_q   <= 1'b0;
            dat_q   <= INI_DATA;
            last_q  <= 1'b0;
            src_q   <= '0;
        end else if (ld_en) begin
            vld_q <= xfer;
            if (xfer) begin
                dat_q  <= dat_arr[grant_idx];
                last_q <= xfer_last;
                src_q  <= grant_idx;

                unique case (state_q)
                    ARB: begin
                        if (!xfer_last) begin
                            state_q <= LOCK;
                            owner_q <= grant_idx;
                        end
                    end
                    LOCK: begin
                        if (xfer_last) state_q <= ARB;
                    end
                    default: state_q <= ARB;
                endcase

                // Fairness advances per packet, never mid-packet.
                if (xfer_last) ptr_q <= ptr_inc;
            end
        end
    end

    assign bus.iRdy  = rdy;
    assign bus.oVld  = vld_q;
    assign bus.oDat  = dat_q;
    assign bus.oLast = last_q;
    assign bus.oSrc  = src_q;
endmodule

// File: doc/rr_arb_reg_slice.md
RR_ARB_REG_SLICE -- requirements
Module: rr_arb_reg_slice

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, payload width per requester; SHALL be >= 1.
REQ-003 Parameter INI_DATA, default '0, value driven on oDat after reset.
REQ-004 SRC_W SHALL equal max(1, $clog2(NUM_REQ)).
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 iVld  input  NUM_REQ  per-requester beat valid.
REQ-008 iLast  input  NUM_REQ  per-requester last beat of a packet.
REQ-009 iDat  input  NUM_REQ*DATA_WIDTH  payloads, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 iRdy  output  NUM_REQ  per-requester accept, combinational, at most one bit high.
REQ-011 oVld  output  1  registered output beat valid.
REQ-012 oDat  output  DATA_WIDTH  registered output payload.
REQ-013 oLast  output  1  registered last flag of the output beat.
REQ-014 oSrc  output  SRC_W  index of the requester that sourced the output beat.
REQ-015 oRdy  input  1  downstream accept.

Function
REQ-016 Output register SHALL be loadable (ld_en) when oVld==0 or oRdy==1.
REQ-017 A transfer from requester k SHALL occur when iVld[k] && iRdy[k]; iRdy[k] SHALL be 1 only if ld_en and k is the current grantee.
REQ-018 On transfer, oVld<=1, oDat<=iDat[k], oLast<=iLast[k], oSrc<=k at the next edge; latency input-to-output exactly 1 cycle.
REQ-019 If ld_en and no transfer occurs, oVld<=0; oDat/oLast/oSrc SHALL hold.
REQ-020 If oVld && !oRdy, all output registers SHALL hold; no iRdy bit high.
REQ-021 FSM states ARB and LOCK; owner register SRC_W bits; round-robin pointer ptr SRC_W bits.
REQ-022 In ARB, grantee SHALL be the first k with iVld[k]==1 searching ptr, ptr+1, ..., wrapping modulo NUM_REQ; no grantee if all iVld==0.
REQ-023 In ARB, a transfer with iLast==0 SHALL move to LOCK with owner<=k; with iLast==1 SHALL stay ARB.
REQ-024 In LOCK, grantee SHALL be owner only; other requesters SHALL see iRdy==0 regardless of iVld.
REQ-025 In LOCK, a transfer with iLast==1 SHALL return to ARB; owner deasserting iVld SHALL NOT release LOCK.
REQ-026 ptr SHALL update to (k+1) mod NUM_REQ only on a transfer with iLast==1 (packet end); ptr==NUM_REQ-1 SHALL wrap to 0.
REQ-027 Arbitration SHALL NOT depend on oRdy except through ld_en; a request lost while ld_en==0 SHALL be re-arbitrated next cycle with unchanged ptr.
REQ-028 Requesters SHALL NOT be required to hold iVld; the block SHALL NOT depend on requester stability.
REQ-029 Single-beat packets (iLast==1 on first beat) SHALL never enter LOCK.

Reset
REQ-030 When rst==1 at a clock edge: oVld<=0, oDat<=INI_DATA, oLast<=0, oSrc<=0, ptr<=0, owner<=0, state<=ARB.
REQ-031 While rst==1, iRdy SHALL be all zero; no transfer SHALL be recorded.
REQ-032 rst asserted mid-packet (LOCK) SHALL abandon the packet; first post-reset grant follows REQ-022 from ptr 0.

Verification
REQ-033 Reset, NUM_REQ=4, INI_DATA=8'hA5 -> oVld=0, oDat=8'hA5, oSrc=0, iRdy=4'b0000.
REQ-034 iVld=4'b1111, iLast=4'b1111, oRdy=1 held 8 cycles -> oSrc sequence 0,1,2,3,0,1,2,3, oVld=1 from cycle 2.
REQ-035 Req 1 sends 3-beat packet (last on beat 3) while req 0,2 valid -> oSrc=1,1,1 consecutive, then 2, then 0 next.
REQ-036 oVld=1, oRdy=0 for 3 cycles with iVld=4'b0010 -> oDat/oSrc stable, iRdy=0; oRdy=1 -> req 1 beat loaded next cycle.
REQ-037 Owner 2 in LOCK drops iVld 2 cycles while req 0 valid -> iRdy[0]=0 throughout, oVld falls to 0, LOCK held until req 2 last beat.
REQ-038 rst pulse during LOCK owner 3 -> post-reset, iVld=4'b1001 grants req 0 first.
